remote_transmitter: RTL

Serial frame generator that sits directly upstream of remote_controller and drives its serial input. It accepts 8-bit key codes over a valid/ready handshake and emits one frame per key, one bit per clk. Frame order: start pair, 16-bit custom code, key code, inverted key code, end gap. A one-entry pending buffer allows back-to-back frames. An optional corrupt flag transmits a bad inverted field so receiver reject paths can be exercised.

---
 rtl/rc_pkg.sv | 28 ++
 rtl/rc_piso.sv | 36 +++
 rtl/remote_transmitter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rc_pkg.sv
// Shared constants and state encoding for the remote-control link
// (transmitter and remote_controller receiver).
package rc_pkg;

  localparam int unsigned START_LEN  = 2;
  localparam int unsigned CUSTOM_LEN = 16;
  localparam int unsigned KEY_LEN    = 8;
  localparam int unsigned INV_LEN    = 8;
  localparam int unsigned PISO_W     = 16;

  localparam logic [15:0] CUSTOM_CODE_DEF = 16'hAAAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LO,
    ST_START_HI,
    ST_CUSTOM,
    ST_KEY,
    ST_INV,
    ST_END
  } rc_state_e;

  // Counter reload value for a field of len cycles.
  function automatic logic [4:0] field_last(input int unsigned len);
    return 5'(len - 1);
  endfunction

endpackage

// File: rtl/rc_piso.sv
// 16-bit parallel-load, MSB-first shift register.
// sout_d is the MSB the register will hold after this clock edge.
module rc_piso
  import rc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [PISO_W-1:0] din,
  output logic              sout_d
);

  logic [PISO_W-1:0] sr_q;
  logic [PISO_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[PISO_W-2:0], 1'b0};
    end
  end

  assign sout_d = sr_d[PISO_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/remote_transmitter.sv
// Serial frame generator: start pair, custom code, key, inverted key,
// end gap. One-entry pending buffer allows back-to-back frames.
module remote_transmitter
  import rc_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE  = CUSTOM_CODE_DEF,
  parameter int unsigned END_LEN      = 5,
  parameter logic [7:0]  CORRUPT_MASK = 8'h22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_in,
  input  logic       key_corrupt,
  output logic       key_ready,
  output logic       serial,
  output logic       busy,
  output logic       frame_done
);

  rc_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  act_key_q, act_key_d;
  logic        act_cor_q, act_cor_d;
  logic [7:0]  pend_key_q, pend_key_d;
  logic        pend_cor_q, pend_cor_d;
  logic        pend_full_q, pend_full_d;
  logic        serial_q, serial_d;
  logic        done_q, done_d;

  logic        accept;
  logic        field_end;
  logic [7:0]  inv_field;
  logic        piso_load;
  logic        piso_shift;
  logic [15:0] piso_din;
  logic        piso_sout;

  assign key_ready  = !pend_full_q;
  assign accept     = key_valid && key_ready;
  assign field_end  = (cnt_q == 5'd0);
  assign busy       = (state_q != ST_IDLE);
  assign serial     = serial_q;
  assign frame_done = done_q;

  assign inv_field = ~act_key_q ^ (act_cor_q ? CORRUPT_MASK : 8'h00);
  assign piso_din  = (state_q == ST_START_HI) ? CUSTOM_CODE
                                              : {act_key_q, inv_field};

  rc_piso u_piso (
    .clk    (clk),
    .reset  (reset),
    .load   (piso_load),
    .shift  (piso_shift),
    .din    (piso_din),
    .sout_d (piso_sout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = field_end ? cnt_q : cnt_q - 5'd1;
    act_key_d   = act_key_q;
    act_cor_d   = act_cor_q;
    pend_key_d  = pend_key_q;
    pend_cor_d  = pend_cor_q;
    pend_full_d = pend_full_q;
    done_d      = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    serial_d    = 1'b1;

    if (accept && state_q != ST_IDLE) begin
      pend_key_d  = key_in;
      pend_cor_d  = key_corrupt;
      pend_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START_LO;
          cnt_d     = field_last(START_LEN / 2);
          act_key_d = key_in;
          act_cor_d = key_corrupt;
        end
      end
      ST_START_LO: begin
        state_d = ST_START_HI;
        cnt_d   = field_last(START_LEN / 2);
      end
      ST_START_HI: begin
        state_d   = ST_CUSTOM;
        cnt_d     = field_last(CUSTOM_LEN);
        piso_load = 1'b1;
      end
      ST_CUSTOM: begin
        if (field_end) begin
          state_d   = ST_KEY;
          cnt_d     = field_last(KEY_LEN);
          piso_load = 1'b1;
        end else begin
          piso_shift = 1'b1;
        end
      end
      ST_KEY: begin
        // key and inv share one load, so the last key bit still shifts
        piso_shift = 1'b1;
        if (field_end) begin
          state_d = ST_INV;
          cnt_d   = field_last(INV_LEN);
        end
      end
      ST_INV: begin
        if (field_end) begin
          state_d = ST_END;
          cnt_d   = 5'(END_LEN - 1);
        end else begin
          piso_shift = 1'b1;
        end
      end
      ST_END: begin
        if (field_end) begin
          done_d = 1'b1;
          if (pend_full_q) begin
            state_d     = ST_START_LO;
            cnt_d       = field_last(START_LEN / 2);
            act_key_d   = pend_key_q;
            act_cor_d   = pend_cor_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            state_d     = ST_START_LO;
            cnt_d       = field_last(START_LEN / 2);
            act_key_d   = key_in;
            act_cor_d   = key_corrupt;
            pend_full_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    unique case (state_d)
      ST_IDLE:     serial_d = 1'b1;
      ST_START_LO: serial_d = 1'b0;
      ST_START_HI: serial_d = 1'b1;
      ST_CUSTOM,
      ST_KEY,
      ST_INV:      serial_d = piso_sout;
      ST_END:      serial_d = 1'b0;
      default:     serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_key_q   <= '0;
      act_cor_q   <= 1'b0;
      pend_key_q  <= '0;
      pend_cor_q  <= 1'b0;
      pend_full_q <= 1'b0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_key_q   <= act_key_d;
      act_cor_q   <= act_cor_d;
      pend_key_q  <= pend_key_d;
      pend_cor_q  <= pend_cor_d;
      pend_full_q <= pend_full_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

endmodule
